// File: rtl/rapcla_pkg.sv
// Shared types, default sizing and the segment-propagate helper for the RAPCLA error-recovery block.
package rapcla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;
    localparam int MAX_SEG   = 32;

    // A segment propagates only when every bit of a^b in it is set.
    function automatic logic seg_prop(input logic [MAX_SEG-1:0] t, input int seg);
        logic p;
        p = 1'b1;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (i < seg) p = p & t[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/rapcla_err_recovery_if.sv
// Operand/result handshake bundle between the requesting datapath (master) and rapcla_err_recovery (slave).
interface rapcla_err_recovery_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] approx_sum;
    logic             err;
    logic [15:0]      err_count;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, approx_sum, err, err_count
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, approx_sum, err, err_count
    );
endinterface

// File: rtl/rapcla_err_recovery_seg_gp.sv
// Combinational group generate / propagate for one SEG-bit segment (carry-in excluded).
module rapcla_seg_gp
    import rapcla_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    output logic           g_o,
    output logic           p_o
);
    logic [MAX_SEG-1:0] propBits;

    assign propBits = MAX_SEG'(a_i ^ b_i);
    assign g_o      = 1'(({1'b0, a_i} + {1'b0, b_i}) >> SEG);
    assign p_o      = seg_prop(propBits, SEG);
endmodule

// File: rtl/rapcla_err_recovery.sv
// Variable-latency RAPCLA consumer: forms the speculative sum, then walks segments fixing mis-speculated carries.
// Optional saturating error counter enabled by defining RAPCLA_ERR_CNT_EN.
module rapcla_err_recovery
    import rapcla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input logic                 clk,
    input logic                 rst,
    rapcla_err_recovery_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    state_t           state_q;
    logic             in_ready_q, out_valid_q, cout_q, err_q, carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, approx_q;
    logic [NSEG-1:0]  g_q, p_q, spec_q;
    logic [KW-1:0]    k_q;

    logic [NSEG-1:0]  gIn, pIn, specIn;
    logic [WIDTH-1:0] approxIn;
    logic             anyProp, fastCout, carry_d, mispred;
    logic [SEG-1:0]   walkSeg_d;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        rapcla_seg_gp #(.SEG(SEG)) u_gp (
            .a_i (bus.a[gi*SEG +: SEG]),
            .b_i (bus.b[gi*SEG +: SEG]),
            .g_o (gIn[gi]),
            .p_o (pIn[gi])
        );
    end

    // Speculation: the carry into segment k is assumed to be the previous segment's generate alone.
    always_comb begin
        specIn    = '0;
        approxIn  = '0;
        anyProp   = 1'b0;
        specIn[0] = bus.cin;
        for (int k = 1; k < NSEG; k++) specIn[k] = gIn[k-1];
        for (int k = 0; k < NSEG; k++) begin
            approxIn[k*SEG +: SEG] = SEG'({1'b0, bus.a[k*SEG +: SEG]} + {1'b0, bus.b[k*SEG +: SEG]}
                                          + {{SEG{1'b0}}, specIn[k]});
        end
        for (int k = 0; k < NSEG - 1; k++) anyProp = anyProp | pIn[k];
        fastCout = gIn[NSEG-1] | (pIn[NSEG-1] & specIn[NSEG-1]);
    end

    always_comb begin
        walkSeg_d = SEG'({1'b0, a_q[k_q*SEG +: SEG]} + {1'b0, b_q[k_q*SEG +: SEG]}
                         + {{SEG{1'b0}}, carry_q});
        carry_d   = g_q[k_q] | (p_q[k_q] & carry_q);
        mispred   = carry_q != spec_q[k_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            approx_q    <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            g_q         <= '0;
            p_q         <= '0;
            spec_q      <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        g_q        <= gIn;
                        p_q        <= pIn;
                        spec_q     <= specIn;
                        sum_q      <= approxIn;
                        approx_q   <= approxIn;
                        carry_q    <= gIn[0] | (pIn[0] & bus.cin);
                        k_q        <= KW'(1);
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        // With no propagating segment below the top, every speculated carry is exact.
                        if (!anyProp) begin
                            cout_q      <= fastCout;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= WALK;
                        end
                    end
                end
                WALK: begin
                    if (mispred) begin
                        sum_q[k_q*SEG +: SEG] <= walkSeg_d;
                        err_q                 <= 1'b1;
                    end
                    carry_q <= carry_d;
                    k_q     <= k_q + 1'b1;
                    if (k_q == KW'(NSEG - 1)) begin
                        cout_q      <= carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sum        = sum_q;
    assign bus.approx_sum = approx_q;
    assign bus.cout       = cout_q;
    assign bus.err        = err_q;

`ifdef RAPCLA_ERR_CNT_EN
    logic [15:0] errCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCnt_q <= '0;
        end else if (state_q == DONE && bus.out_ready && err_q && errCnt_q != 16'hFFFF) begin
            errCnt_q <= errCnt_q + 16'd1;
        end
    end

    assign bus.err_count = errCnt_q;
`else
    assign bus.err_count = '0;
`endif
endmodule
